regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and written on cycles the pipeline leaves the port idle. If a result waits too long, the arbiter stalls writeback for one cycle to drain it. It sits between the writeback stage's `rd_data` path, the MDU result bus and the regfile write port, and registers the write port.

---
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between the pipeline writeback stage and a
// FIFO of buffered MDU results. A head that waits too long takes the port by stalling writeback.
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] MAXW_C  = WW'(MAX_WAIT);

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [4:0]    rd_mem_d   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          busy_q, busy_d;
  logic          mdu_ready_q, mdu_ready_d;

  logic nonempty_s, wb_eff_s, force_s, grant_fifo_s, grant_wb_s, push_s;

  // Grant decision: FORCE > PIPE > DRAIN > IDLE; register zero counts as no write request.
  always_comb begin
    nonempty_s   = (count_q != {CW{1'b0}});
    wb_eff_s     = wb_valid && (wb_rd != 5'd0);
    force_s      = nonempty_s && (wcnt_q == MAXW_C);
    grant_fifo_s = force_s || (nonempty_s && !wb_eff_s);
    grant_wb_s   = !force_s && wb_eff_s;
    push_s       = mdu_valid && mdu_ready_q && (mdu_rd != 5'd0);
    wb_stall     = force_s && wb_valid;
  end

  // FIFO storage, pointers, occupancy and head wait counter.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push_s) begin
      rd_mem_d[wptr_q]   = mdu_rd;
      data_mem_d[wptr_q] = mdu_data;
      wptr_d             = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (grant_fifo_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    if (push_s && !grant_fifo_s) begin
      count_d = count_q + CW'(1);
    end else if (!push_s && grant_fifo_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // A new head after a pop always starts its wait from zero.
    if (grant_fifo_s || !nonempty_s) begin
      wcnt_d = {WW{1'b0}};
    end else if (wcnt_q != MAXW_C) begin
      wcnt_d = wcnt_q + WW'(1);
    end else begin
      wcnt_d = wcnt_q;
    end

    busy_d      = (count_d != {CW{1'b0}});
    mdu_ready_d = (count_d < DEPTH_C);
  end

  // Write port next-state: address and data hold when nothing is granted.
  always_comb begin
    if (grant_fifo_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = rd_mem_q[rptr_q];
      rf_wdata_d = data_mem_q[rptr_q];
    end else if (grant_wb_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // State registers; reset discards any buffered MDU results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
      wptr_q      <= {PW{1'b0}};
      rptr_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      wcnt_q      <= {WW{1'b0}};
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      busy_q      <= 1'b0;
      mdu_ready_q <= 1'b1;
    end else begin
      rd_mem_q    <= rd_mem_d;
      data_mem_q  <= data_mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      busy_q      <= busy_d;
      mdu_ready_q <= mdu_ready_d;
    end
  end

  assign mdu_ready = mdu_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: a queue-based reference model
// predicts each regfile write; a monitor compares every rf_we cycle against it.
module tb_regfile_write_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        wb_stall;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  typedef struct packed { int c; logic [4:0] rd; logic [31:0] d; } exp_t;

  ent_t fifo_m[$];
  exp_t exp_q[$];
  int   wait_m = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic stall_prev = 1'b0;
  logic mhold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: every asserted rf_we must match the oldest predicted write, in the predicted cycle.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    cyc++;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(rf_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", cyc, e.c);
        chk("write_addr", 32'(rf_waddr), 32'(e.rd));
        chk("write_data", rf_wdata, e.d);
      end
    end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
      chk("missing_write", 32'(rf_we), 32'd1);
      void'(exp_q.pop_front());
    end
  end

  // One cycle: check registered status, apply inputs (honouring stall / backpressure holds), predict.
  task automatic step(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    logic wbe, frc, stall_e, acc;
    ent_t h;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(fifo_m.size() != 0));
    chk("mdu_ready", 32'(mdu_ready), 32'(fifo_m.size() < DEPTH));
    if (!stall_prev) begin
      wb_valid = wv; wb_rd = wr; wb_data = wd;
    end
    if (!mhold) begin
      mdu_valid = mv; mdu_rd = mr; mdu_data = md;
    end
    #1;
    wbe     = wb_valid && (wb_rd != 5'd0);
    frc     = (fifo_m.size() != 0) && (wait_m == MAX_WAIT);
    stall_e = frc && wb_valid;
    chk("wb_stall", 32'(wb_stall), 32'(stall_e));
    acc = mdu_valid && (fifo_m.size() < DEPTH);
    if (frc || (!wbe && fifo_m.size() != 0)) begin
      h = fifo_m.pop_front();
      exp_q.push_back('{c: cyc + 1, rd: h.rd, d: h.d});
      wait_m = 0;
    end else if (wbe) begin
      exp_q.push_back('{c: cyc + 1, rd: wb_rd, d: wb_data});
      if (fifo_m.size() != 0) wait_m = (wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT;
      else wait_m = 0;
    end else begin
      wait_m = 0;
    end
    if (acc && mdu_rd != 5'd0) fifo_m.push_back('{rd: mdu_rd, d: mdu_data});
    mhold      = mdu_valid && !acc;
    stall_prev = stall_e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; mdu_valid = 1'b0;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    wb_valid = 1'b0;
    fifo_m.delete(); exp_q.delete();
    wait_m = 0; stall_prev = 1'b0; mhold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin : stim
    int dwb, dmd;
    do_reset();
    // Idle pipeline: single MDU result drains two cycles later.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle(4);
    // Continuous writeback with one buffered result: forced after MAX_WAIT denials.
    step(1'b1, 5'd3, 32'h1111_0000, 1'b1, 5'd7, 32'hCAFE_0007);
    for (int i = 0; i < 9; i++) step(1'b1, 5'(8 + i), 32'h2222_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    idle(3);
    // Fill to DEPTH, third result held off by mdu_ready, order kept across wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd1, 32'h3333_0000 + 32'(i), 1'b1, 5'(9 + i), 32'h4444_0000 + 32'(i));
    for (int i = 0; i < 12; i++) step(1'b1, 5'd2, 32'h5555_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    idle(4);
    // Register zero from both sources.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 32'h6666_0000, 1'b1, 5'd0, 32'h7777_0000);
    idle(3);
    // Reset mid-drain with two entries queued.
    step(1'b1, 5'd4, 32'h8888_0001, 1'b1, 5'd12, 32'h9999_0001);
    step(1'b1, 5'd4, 32'h8888_0002, 1'b1, 5'd13, 32'h9999_0002);
    do_reset();
    idle(4);
    // Randomized traffic in phases of varying density, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      case (i / 750)
        0:       begin dwb = 30; dmd = 30; end
        1:       begin dwb = 90; dmd = 40; end
        2:       begin dwb = 100; dmd = 70; end
        default: begin dwb = 60; dmd = 60; end
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      step(32'($urandom_range(0, 99)) < 32'(dwb), 5'($urandom_range(0, 31)), $urandom,
           32'($urandom_range(0, 99)) < 32'(dmd), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(20);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
